sram_tdm_mux: RTL and testbench

//  Parametrised time-division multiplexer giving NPORTS masters (video fetch, CPU, DMA...) shared

---
 rtl/sram_tdm_mux.sv | 123 ++++++++++++
 tb/tb_sram_tdm_mux.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_tdm_mux.sv
// Round-robin time-division multiplexer sharing one asynchronous SRAM among NPORTS masters.
// Each port owns a two-clock slot: SETUP registers address/OE, ACCESS drops WE for writes.
module sram_tdm_mux #(
  parameter int                AW      = 19,
  parameter int                DW      = 8,
  parameter int                NPORTS  = 2,
  parameter logic [NPORTS-1:0] RO_MASK = NPORTS'(1)
) (
  input  logic                 clk12,
  input  logic                 rst,
  input  logic [NPORTS*AW-1:0] port_addr,
  input  logic [NPORTS-1:0]    port_we_n,
  input  logic [NPORTS*DW-1:0] port_wdata,
  output logic [NPORTS*DW-1:0] port_rdata,
  output logic [NPORTS-1:0]    port_rvalid,
  output logic [NPORTS-1:0]    port_wdone,
  output logic [1:0]           slot,
  output logic [AW-1:0]        sram_a,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  inout  wire  [DW-1:0]        sram_d
);

  localparam int SW = (NPORTS > 2) ? 2 : 1;

  if (NPORTS < 2 || NPORTS > 4) begin : g_bad_nports
    $error("sram_tdm_mux: NPORTS must be in 2..4");
  end

  // PH_IDLE only exists after reset so the first slot starts cleanly at port 0.
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

  phase_t            ph_q, ph_d;
  logic [SW-1:0]     slot_q, slot_d, next_s;
  logic              wreq_q, wreq_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [AW-1:0]     sram_a_q, sram_a_d;
  logic              sram_we_n_q, sram_we_n_d;
  logic              sram_oe_n_q, sram_oe_n_d;
  logic [DW-1:0]     rdata_q [NPORTS];
  logic [DW-1:0]     rdata_d [NPORTS];
  logic [NPORTS-1:0] rvalid_q, rvalid_d;
  logic [NPORTS-1:0] wdone_q, wdone_d;
  logic [AW-1:0]     addr_arr [NPORTS];
  logic [DW-1:0]     wdat_arr [NPORTS];

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    assign addr_arr[gi]             = port_addr[gi*AW +: AW];
    assign wdat_arr[gi]             = port_wdata[gi*DW +: DW];
    assign port_rdata[gi*DW +: DW]  = rdata_q[gi];
  end

  always_comb begin
    ph_d        = ph_q;
    slot_d      = slot_q;
    wreq_d      = wreq_q;
    wdata_d     = wdata_q;
    sram_a_d    = sram_a_q;
    sram_we_n_d = sram_we_n_q;
    sram_oe_n_d = sram_oe_n_q;
    rdata_d     = rdata_q;
    rvalid_d    = '0;
    wdone_d     = '0;
    next_s      = '0;
    if (ph_q == PH_SETUP) begin
      ph_d        = PH_ACCESS;
      sram_we_n_d = ~wreq_q;
    end else begin
      if (ph_q == PH_ACCESS) begin
        next_s = (slot_q == SW'(NPORTS - 1)) ? '0 : slot_q + 1'b1;
        if (wreq_q) begin
          wdone_d[slot_q] = 1'b1;
        end else begin
          rdata_d[slot_q]  = sram_d;
          rvalid_d[slot_q] = 1'b1;
        end
      end
      // Enter SETUP of the next slot: sample that port's request.
      ph_d        = PH_SETUP;
      slot_d      = next_s;
      sram_a_d    = addr_arr[next_s];
      wreq_d      = ~port_we_n[next_s] & ~RO_MASK[next_s];
      wdata_d     = wdat_arr[next_s];
      sram_we_n_d = 1'b1;
      sram_oe_n_d = wreq_d;
    end
  end

  always_ff @(posedge clk12) begin
    if (rst) begin
      ph_q        <= PH_IDLE;
      slot_q      <= '0;
      wreq_q      <= 1'b0;
      wdata_q     <= '0;
      sram_a_q    <= '0;
      sram_we_n_q <= 1'b1;
      sram_oe_n_q <= 1'b1;
      rvalid_q    <= '0;
      wdone_q     <= '0;
      for (int k = 0; k < NPORTS; k++) rdata_q[k] <= '0;
    end else begin
      ph_q        <= ph_d;
      slot_q      <= slot_d;
      wreq_q      <= wreq_d;
      wdata_q     <= wdata_d;
      sram_a_q    <= sram_a_d;
      sram_we_n_q <= sram_we_n_d;
      sram_oe_n_q <= sram_oe_n_d;
      rvalid_q    <= rvalid_d;
      wdone_q     <= wdone_d;
      rdata_q     <= rdata_d;
    end
  end

  assign slot        = 2'(slot_q);
  assign sram_a      = sram_a_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_oe_n   = sram_oe_n_q;
  assign port_rvalid = rvalid_q;
  assign port_wdone  = wdone_q;
  assign sram_d      = sram_we_n_q ? 'z : wdata_q;

endmodule

// File: tb/tb_sram_tdm_mux.sv
// Bench for sram_tdm_mux: directed vector table, corner sequences and a randomized
// run checked against a slot-timeline model of the shared SRAM.
module tb_sram_tdm_mux;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int N  = 3;
  localparam logic [N-1:0] RO = 3'b001;
  localparam logic [AW-1:0] P2A0 = 19'h00011;
  localparam logic [AW-1:0] P2A1 = 19'h70022;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: three ports, port 0 read-only
  logic [N*AW-1:0] port_addr;
  logic [N-1:0]    port_we_n;
  logic [N*DW-1:0] port_wdata;
  logic [N*DW-1:0] port_rdata;
  logic [N-1:0]    port_rvalid, port_wdone;
  logic [1:0]      slot;
  logic [AW-1:0]   sram_a;
  logic            sram_we_n, sram_oe_n;
  wire  [DW-1:0]   sram_d;

  sram_tdm_mux #(.AW(AW), .DW(DW), .NPORTS(N), .RO_MASK(RO)) dut (
    .clk12(clk), .rst(rst), .port_addr(port_addr), .port_we_n(port_we_n),
    .port_wdata(port_wdata), .port_rdata(port_rdata), .port_rvalid(port_rvalid),
    .port_wdone(port_wdone), .slot(slot), .sram_a(sram_a), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_d(sram_d));

  // Second instance with default parameters (two ports)
  logic [2*AW-1:0] p2_addr;
  logic [1:0]      p2_we_n;
  logic [2*DW-1:0] p2_wdata;
  logic [2*DW-1:0] p2_rdata;
  logic [1:0]      p2_rvalid, p2_wdone, p2_slot;
  logic [AW-1:0]   p2_sram_a;
  logic            p2_sram_we_n, p2_sram_oe_n;
  wire  [DW-1:0]   p2_sram_d;

  sram_tdm_mux dut2 (
    .clk12(clk), .rst(rst), .port_addr(p2_addr), .port_we_n(p2_we_n),
    .port_wdata(p2_wdata), .port_rdata(p2_rdata), .port_rvalid(p2_rvalid),
    .port_wdone(p2_wdone), .slot(p2_slot), .sram_a(p2_sram_a), .sram_we_n(p2_sram_we_n),
    .sram_oe_n(p2_sram_oe_n), .sram_d(p2_sram_d));

  assign p2_sram_d = (!p2_sram_oe_n && p2_sram_we_n) ? (p2_sram_a[7:0] ^ 8'h5A) : 8'hzz;

  // Asynchronous SRAM model: drives data on OE, stores while WE is low
  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_a = '0;
  logic [7:0]  pl_d = '0;
  assign sram_d = (!sram_oe_n && sram_we_n) ? mem[sram_a[15:0]] : 8'hzz;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!sram_we_n) mem[sram_a[15:0]] <= sram_d;
  end

  // Edges since reset release; edge n enters slot (n/2)%N, phase n%2
  int ecnt = 0;
  always @(posedge clk) begin
    if (rst) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    port_addr[p*AW +: AW]  = a;
    port_we_n[p]           = we;
    port_wdata[p*DW +: DW] = d;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_setup(input int p);
    bit found = 1'b0;
    for (int i = 0; i < 2*N + 2 && !found; i++) begin
      @(posedge clk); #1;
      if (ecnt > 0 && (ecnt - 1) % 2 == 0 && ((ecnt - 1) / 2) % N == p) found = 1'b1;
    end
    chk("setup_seen", {31'b0, found}, 32'd1);
  endtask

  task automatic do_txn(input int p, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                        output logic [N-1:0] rv, output logic [N-1:0] wd, output logic [DW-1:0] rd);
    logic wr;
    wr = !we && !RO[p];
    @(negedge clk);
    set_port(p, a, we, d);
    wait_setup(p);
    chk("setup_addr", sram_a, a);
    chk("setup_slot", slot, p);
    chk("setup_we_n", sram_we_n, 1);
    chk("setup_oe_n", sram_oe_n, wr);
    @(negedge clk);
    set_port(p, ~a, 1'b1, ~d);  // late change must not disturb the slot
    @(posedge clk); #1;
    chk("access_addr", sram_a, a);
    chk("access_we_n", sram_we_n, !wr);
    if (wr) chk("access_data", sram_d, d);
    @(posedge clk); #1;
    rv = port_rvalid;
    wd = port_wdone;
    rd = port_rdata[p*DW +: DW];
    @(negedge clk);
    set_port(p, a, 1'b1, d);
  endtask

  typedef struct {
    int            port;
    logic [AW-1:0] addr;
    logic          we_n;
    logic [DW-1:0] wdata;
    logic [N-1:0]  exp_rv;
    logic [N-1:0]  exp_wd;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t tbl [9];

  logic [N-1:0]    rv, wd, exp_rv, exp_wd;
  logic [DW-1:0]   rd;
  logic [7:0]      ref_mem [16];
  logic [DW-1:0]   ref_rd [N];
  logic [N*DW-1:0] exp_pk;
  logic [AW-1:0]   in_a [N];
  logic            in_we [N];
  logic [DW-1:0]   in_d [N];
  int              cur_p;
  logic [AW-1:0]   cur_a;
  logic            cur_wr;
  logic [DW-1:0]   cur_d;

  initial begin
    tbl[0] = '{0, 19'h01234, 1'b1, 8'h00, 3'b001, 3'b000, 8'h5A};
    tbl[1] = '{1, 19'h01234, 1'b0, 8'hA5, 3'b000, 3'b010, 8'h00};
    tbl[2] = '{0, 19'h01234, 1'b1, 8'h00, 3'b001, 3'b000, 8'hA5};
    tbl[3] = '{0, 19'h01234, 1'b0, 8'hFF, 3'b001, 3'b000, 8'hA5};
    tbl[4] = '{2, 19'h01234, 1'b1, 8'h00, 3'b100, 3'b000, 8'hA5};
    tbl[5] = '{2, 19'h00042, 1'b0, 8'h3C, 3'b000, 3'b100, 8'h00};
    tbl[6] = '{1, 19'h00042, 1'b1, 8'h00, 3'b010, 3'b000, 8'h3C};
    tbl[7] = '{1, 19'h70042, 1'b0, 8'hC3, 3'b000, 3'b010, 8'h00};
    tbl[8] = '{0, 19'h70042, 1'b1, 8'h00, 3'b001, 3'b000, 8'hC3};

    rst = 1'b1;
    port_addr = '0; port_we_n = '1; port_wdata = '0;
    p2_addr = {P2A1, P2A0}; p2_we_n = 2'b10; p2_wdata = 16'hBEEF;
    repeat (3) @(negedge clk);

    chk("rst_slot", slot, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_addr", sram_a, 0);
    chk("rst_rvalid", port_rvalid, 0);
    chk("rst_wdone", port_wdone, 0);
    chk("rst_rdata", port_rdata, 0);

    // Two-port instance: slot order, address alternation, read-only port 0
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      int s, pp;
      @(posedge clk); #1;
      s = (k / 2) % 2;
      chk("n2_slot", p2_slot, s);
      chk("n2_addr", p2_sram_a, (s == 1) ? P2A1 : P2A0);
      chk("n2_we_n", p2_sram_we_n, 1);
      chk("n2_wdone", p2_wdone, 0);
      if (k % 2 == 0 && k > 0) begin
        pp = 1 - s;
        chk("n2_rvalid", p2_rvalid, 1 << pp);
        chk("n2_rdata", p2_rdata[pp*DW +: DW], ((pp == 1) ? P2A1[7:0] : P2A0[7:0]) ^ 8'h5A);
      end else begin
        chk("n2_rvalid_idle", p2_rvalid, 0);
      end
    end

    // Directed vector table on the three-port instance
    @(negedge clk);
    rst = 1'b1;
    preload(16'h1234, 8'h5A);
    preload(16'h0077, 8'h00);
    preload(16'h0055, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i].port, tbl[i].addr, tbl[i].we_n, tbl[i].wdata, rv, wd, rd);
      chk($sformatf("vec%0d_rvalid", i), rv, tbl[i].exp_rv);
      chk($sformatf("vec%0d_wdone", i), wd, tbl[i].exp_wd);
      if (tbl[i].exp_rv != 0) chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
    end

    // Back-to-back writes to one address from ports 1 and 2, then port 0 reads it
    @(negedge clk);
    set_port(1, 19'h00077, 1'b0, 8'h11);
    set_port(2, 19'h00077, 1'b0, 8'h22);
    set_port(0, 19'h00077, 1'b1, 8'h00);
    wait_setup(1);
    repeat (2) @(posedge clk); #1;
    chk("b2b_wdone1", port_wdone, 3'b010);
    repeat (2) @(posedge clk); #1;
    chk("b2b_wdone2", port_wdone, 3'b100);
    repeat (2) @(posedge clk); #1;
    chk("b2b_rvalid0", port_rvalid, 3'b001);
    chk("b2b_rdata0", port_rdata[0 +: DW], 8'h22);
    @(negedge clk);
    port_we_n = '1;

    // Reset while port 1's write slot is in progress
    set_port(1, 19'h00055, 1'b0, 8'h77);
    wait_setup(1);
    @(negedge clk);
    rst = 1'b1;
    set_port(1, 19'h00055, 1'b1, 8'h77);
    @(posedge clk); #1;
    chk("midrst_we_n", sram_we_n, 1);
    chk("midrst_oe_n", sram_oe_n, 1);
    chk("midrst_slot", slot, 0);
    chk("midrst_addr", sram_a, 0);
    chk("midrst_wdone", port_wdone, 0);
    chk("midrst_rdata", port_rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_slot", slot, 0);
    chk("postrst_addr", sram_a, port_addr[0 +: AW]);
    chk("postrst_wdone", port_wdone, 0);
    do_txn(2, 19'h00055, 1'b1, 8'h00, rv, wd, rd);
    chk("postrst_rvalid", rv, 3'b100);
    chk("postrst_unchanged", rd, 8'h00);

    // Randomized run against the slot-timeline model
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      preload(16'(i), ref_mem[i]);
    end
    for (int p = 0; p < N; p++) ref_rd[p] = '0;
    cur_p = 0; cur_a = '0; cur_wr = 1'b0; cur_d = '0;
    rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      int s;
      for (int p = 0; p < N; p++) begin
        in_a[p]  = {3'($urandom_range(0, 7)), 12'h000, 4'($urandom_range(0, 15))};
        in_we[p] = 1'($urandom_range(0, 1));
        in_d[p]  = 8'($urandom);
        set_port(p, in_a[p], in_we[p], in_d[p]);
      end
      @(posedge clk); #1;
      s = (k / 2) % N;
      exp_rv = '0;
      exp_wd = '0;
      if (k % 2 == 0) begin
        if (k > 0) begin
          if (cur_wr) begin
            ref_mem[cur_a[3:0]] = cur_d;
            exp_wd[cur_p] = 1'b1;
          end else begin
            ref_rd[cur_p] = ref_mem[cur_a[3:0]];
            exp_rv[cur_p] = 1'b1;
          end
        end
        cur_p  = s;
        cur_a  = in_a[s];
        cur_wr = !in_we[s] && !RO[s];
        cur_d  = in_d[s];
        chk("rnd_we_n_setup", sram_we_n, 1);
      end else begin
        chk("rnd_we_n_access", sram_we_n, !cur_wr);
        if (cur_wr) chk("rnd_wdata", sram_d, cur_d);
      end
      for (int p = 0; p < N; p++) exp_pk[p*DW +: DW] = ref_rd[p];
      chk("rnd_slot", slot, s);
      chk("rnd_addr", sram_a, cur_a);
      chk("rnd_oe_n", sram_oe_n, cur_wr);
      chk("rnd_rvalid", port_rvalid, exp_rv);
      chk("rnd_wdone", port_wdone, exp_wd);
      chk("rnd_rdata", port_rdata, exp_pk);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
